avalon_st_generator: RTL and testbench
======================================

# avalon_st_generator

Avalon-ST source that emits the incrementing 16-bit sample pattern consumed by `avalon_st_checker`. It is controlled over an Avalon-MM slave, supports sink backpressure (ready/valid), and can run a fixed number of beats or continuously. It sits opposite the checker in loopback and link test setups, on the same clock.

## Interface
Parameters:
- `DATA_W`, 256: stream data width in bits. Must be a multiple of 16.

Ports:
- `csi_clk_clk`  in  1  clock; the only clock.
- `rsi_reset_reset_n`  in  1  reset. Synchronous, active-low.
- `avs_ctrl_address`  in  4  register word address.
- `avs_ctrl_read`  in  1  read strobe.
- `avs_ctrl_write`  in  1  write strobe.
- `avs_ctrl_readdata`  out  32  registered read data.
- `avs_ctrl_writedata`  in  32  write data.
- `aso_data_data`  out  DATA_W  stream data; 16-bit samples, sample 0 in bits [15:0].
- `aso_data_valid`  out  1  beat valid.
- `aso_data_ready`  in  1  sink ready. readyLatency is 0.

## Operation
- N = DATA_W/16 samples per beat. NR_SYMS = DATA_W/8 bytes per beat.
- Registers. Reads not listed return 0xdeadbeef. Writes not listed are ignored.
  - 0: ID 0xa5157e9e (RO).
  - 1: version 0x00000100 (RO).
  - 2: 0 (RO).
  - 3: scratch (RW). Reset value 0.
  - 4: CTRL (WO; reads return 0). bit0 START, bit1 STOP, bit2 CLEAR. These are pulses.
  - 5: TARGET beats (RW). Reset value 0. A value of 0 means continuous.
  - 6: beats sent (RO).
  - 7: bytes sent = beats × NR_SYMS, mod 2^32 (RO).
  - 8: STATUS (RO). bit0 busy (RUN or STOPPING), bit1 done.
- Pattern: after reset, START or CLEAR, sample i = i. On each accepted beat, every sample increments by N, mod 2^16 per sample.
- A beat is accepted when `aso_data_valid && aso_data_ready`.
- FSM states: IDLE, RUN, STOPPING, DONE. Reset state is IDLE.
  - IDLE → RUN on START. START also clears the pattern, the beat counter and the byte counter.
  - RUN: `aso_data_valid` = 1, except when throttled (see Configuration). If TARGET≠0 and the beat counter reaches TARGET on an acceptance → DONE. STOP → STOPPING.
  - STOPPING: hold the pending beat until it is accepted, then → IDLE. If valid is not asserted, → IDLE on the next cycle.
  - DONE: valid = 0, done = 1. START → RUN, with the same clearing as from IDLE.
  - START is ignored in RUN and STOPPING.
  - CLEAR in any state: → IDLE next cycle, valid deasserted immediately, pattern and counters cleared, done cleared. CLEAR is an abort; the stream hold rule is deliberately violated.
  - Simultaneous CTRL bits: CLEAR > STOP > START.
- Stream hold rule: once `aso_data_valid` rises, data and valid stay stable until acceptance, except on CLEAR or reset.
- Counters wrap at 2^32 without saturating.
- Writing TARGET during RUN takes effect on the next comparison. If the new TARGET ≤ the current count, the block keeps running until the counter wraps around to TARGET.

## Timing
- Reset (low at a rising edge) gives: `aso_data_valid`=0, `aso_data_data` = the initial pattern, `avs_ctrl_readdata`=0, state IDLE, all registers 0.
- Read latency is 1 cycle. `avs_ctrl_readdata` is registered from the address each cycle, independent of `avs_ctrl_read`.
- START written in cycle T → `aso_data_valid`=1 in cycle T+1.
- On acceptance in cycle T: the next pattern appears in cycle T+1, and counters 6 and 7 update in cycle T+1. This gives back-to-back beats at full rate when ready is held high.
- Last accepted beat (count == TARGET) in cycle T: valid=0 and done=1 in cycle T+1.
- Read-during-update returns the pre-update value.

## Configuration
- `AVALON_ST_GENERATOR_THROTTLE_EN`:
  - Defined: register 9 THROTTLE (RW, 8 bits, reset value 0) is added. After each accepted beat, valid stays low for THROTTLE cycles before the next beat is presented. THROTTLE=0 gives full rate. The idle-cycle counter is cleared on START and CLEAR.
  - Not defined: register 9 reads 0xdeadbeef, and valid is never throttled.

## Test plan
- Reset, then read registers 0/1/5/6/8 → 0xa5157e9e, 0x100, 0, 0, 0; `aso_data_valid`=0.
- DATA_W=256, TARGET=4, START, ready=1 → 4 consecutive beats with sample 0 = 0, 16, 32, 48; then done=1, beats=4, bytes=128.
- TARGET=3, ready toggled 1010… → data held stable through every not-ready cycle; 3 beats total, with no duplicated or skipped values.
- TARGET=0, START, run 100 accepted beats, STOP while ready=0 → the pending beat is held until ready returns, accepted, then IDLE; beats=101 if the pending beat was the 101st.
- CLEAR mid-RUN with valid=1, ready=0 → valid=0 next cycle, beats=0, sample 0 = 0; a subsequent START restarts the pattern at 0.
- THROTTLE_EN defined, THROTTLE=2, TARGET=3, ready=1 → beats accepted in cycles T+1, T+4, T+7 after START.

Source files
------------

// File: rtl/avalon_st_generator.sv
// Avalon-ST incrementing 16-bit sample pattern source with an Avalon-MM control slave.
// Latency: START write -> valid next cycle; acceptance -> next pattern and counters next cycle; reads 1 cycle.
// Backpressure: readyLatency 0; a presented beat holds data/valid until accepted (CLEAR/reset abort it).
//
// Ports:
//   csi_clk_clk         single clock
//   rsi_reset_reset_n   synchronous active-low reset
//   avs_ctrl_*          Avalon-MM control slave (4-bit word address, 32-bit data)
//   aso_data_*          Avalon-ST source, sample 0 in bits [15:0]
//
// Optional build macro: AVALON_ST_GENERATOR_THROTTLE_EN adds register 9 (THROTTLE),
// which inserts idle cycles between accepted beats.
//
// Register map (word addresses):
//   0 ID (RO)  1 version (RO)  2 zero (RO)  3 scratch (RW)  4 CTRL (WO pulses: START/STOP/CLEAR)
//   5 TARGET (RW, 0 = continuous)  6 beats sent (RO)  7 bytes sent (RO)  8 STATUS {done, busy} (RO)
//   9 THROTTLE (RW, only with the throttle macro)

module avalon_st_generator #(
    parameter int DATA_W = 256
) (
    input  logic              csi_clk_clk,
    input  logic              rsi_reset_reset_n,
    input  logic [3:0]        avs_ctrl_address,
    input  logic              avs_ctrl_read,
    input  logic              avs_ctrl_write,
    output logic [31:0]       avs_ctrl_readdata,
    input  logic [31:0]       avs_ctrl_writedata,
    output logic [DATA_W-1:0] aso_data_data,
    output logic              aso_data_valid,
    input  logic              aso_data_ready
);

    localparam int          N           = DATA_W / 16;
    localparam logic [15:0] SAMPLE_STEP = 16'(N);
    localparam logic [31:0] BEAT_BYTES  = 32'(DATA_W / 8);
    localparam logic [31:0] ID_VALUE    = 32'ha5157e9e;
    localparam logic [31:0] VER_VALUE   = 32'h00000100;
    localparam logic [31:0] BAD_ADDR    = 32'hdeadbeef;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Sample i = i: the pattern after reset, START and CLEAR.
    function automatic logic [DATA_W-1:0] init_pattern();
        logic [DATA_W-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) begin
            p[i*16 +: 16] = 16'(i);
        end
        return p;
    endfunction

    // Every sample advances by N, wrapping per 16-bit lane.
    function automatic logic [DATA_W-1:0] step_pattern(input logic [DATA_W-1:0] p);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i*16 +: 16] = p[i*16 +: 16] + SAMPLE_STEP;
        end
        return r;
    endfunction

    state_t            state;
    logic              out_vld;
    logic [DATA_W-1:0] out_dat;
    logic [31:0]       beat_cnt;
    logic [31:0]       byte_cnt;
    logic [31:0]       scratch;
    logic [31:0]       target;
    logic              done;
    logic [7:0]        thr_cnt;
    logic [7:0]        gap_cycles;

    // The read strobe carries no side effects: read data is refreshed every cycle.
    logic unused_read;
    assign unused_read = avs_ctrl_read;

`ifdef AVALON_ST_GENERATOR_THROTTLE_EN
    logic [7:0] throttle;

    always_ff @(posedge csi_clk_clk) begin
        if (!rsi_reset_reset_n) begin
            throttle <= 8'd0;
        end else if (avs_ctrl_write && avs_ctrl_address == 4'd9) begin
            throttle <= avs_ctrl_writedata[7:0];
        end
    end

    assign gap_cycles = throttle;
`else
    assign gap_cycles = 8'd0;
`endif

    // Control pulses with CLEAR > STOP > START priority resolved at decode.
    logic ctrl_wr;
    logic clear_cmd;
    logic stop_cmd;
    logic start_cmd;
    logic accept;
    logic busy;

    assign ctrl_wr   = avs_ctrl_write && (avs_ctrl_address == 4'd4);
    assign clear_cmd = ctrl_wr && avs_ctrl_writedata[2];
    assign stop_cmd  = ctrl_wr && avs_ctrl_writedata[1] && !avs_ctrl_writedata[2];
    assign start_cmd = ctrl_wr && avs_ctrl_writedata[0] && !avs_ctrl_writedata[1]
                       && !avs_ctrl_writedata[2];
    assign accept    = out_vld && aso_data_ready;
    assign busy      = (state == RUN) || (state == STOPPING);

    always_ff @(posedge csi_clk_clk) begin
        if (!rsi_reset_reset_n) begin
            state    <= IDLE;
            out_vld  <= 1'b0;
            out_dat  <= init_pattern();
            beat_cnt <= '0;
            byte_cnt <= '0;
            scratch  <= '0;
            target   <= '0;
            done     <= 1'b0;
            thr_cnt  <= '0;
        end else begin
            if (avs_ctrl_write && avs_ctrl_address == 4'd3) begin
                scratch <= avs_ctrl_writedata;
            end
            if (avs_ctrl_write && avs_ctrl_address == 4'd5) begin
                target <= avs_ctrl_writedata;
            end

            if (clear_cmd) begin
                // Abort: drops any presented beat without waiting for acceptance.
                state    <= IDLE;
                out_vld  <= 1'b0;
                out_dat  <= init_pattern();
                beat_cnt <= '0;
                byte_cnt <= '0;
                done     <= 1'b0;
                thr_cnt  <= '0;
            end else begin
                // Acceptance only happens in RUN/STOPPING, so it never races a START.
                if (accept) begin
                    out_dat  <= step_pattern(out_dat);
                    beat_cnt <= beat_cnt + 32'd1;
                    byte_cnt <= byte_cnt + BEAT_BYTES;
                end

                case (state)
                    IDLE, DONE: begin
                        if (start_cmd) begin
                            state    <= RUN;
                            out_vld  <= 1'b1;
                            out_dat  <= init_pattern();
                            beat_cnt <= '0;
                            byte_cnt <= '0;
                            done     <= 1'b0;
                            thr_cnt  <= '0;
                        end
                    end

                    RUN: begin
                        if (stop_cmd) begin
                            // A beat still waiting stays up; STOPPING retires it.
                            state   <= STOPPING;
                            out_vld <= out_vld && !accept;
                        end else if (accept) begin
                            // Compare against the post-increment count; a TARGET at or
                            // below the current count is only reached after wrap.
                            if (target != 32'd0 && (beat_cnt + 32'd1) == target) begin
                                state   <= DONE;
                                out_vld <= 1'b0;
                                done    <= 1'b1;
                            end else if (gap_cycles != 8'd0) begin
                                out_vld <= 1'b0;
                                thr_cnt <= gap_cycles;
                            end else begin
                                out_vld <= 1'b1;
                            end
                        end else if (!out_vld) begin
                            // Throttle gap: raise valid once the last idle cycle is reached.
                            if (thr_cnt <= 8'd1) begin
                                out_vld <= 1'b1;
                                thr_cnt <= '0;
                            end else begin
                                thr_cnt <= thr_cnt - 8'd1;
                            end
                        end
                    end

                    STOPPING: begin
                        if (accept || !out_vld) begin
                            state   <= IDLE;
                            out_vld <= 1'b0;
                        end
                    end

                    default: begin
                        state   <= IDLE;
                        out_vld <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Registered read path: address sampled every cycle, values are pre-update.
    always_ff @(posedge csi_clk_clk) begin
        if (!rsi_reset_reset_n) begin
            avs_ctrl_readdata <= '0;
        end else begin
            case (avs_ctrl_address)
                4'd0:    avs_ctrl_readdata <= ID_VALUE;
                4'd1:    avs_ctrl_readdata <= VER_VALUE;
                4'd2:    avs_ctrl_readdata <= 32'd0;
                4'd3:    avs_ctrl_readdata <= scratch;
                4'd4:    avs_ctrl_readdata <= 32'd0;
                4'd5:    avs_ctrl_readdata <= target;
                4'd6:    avs_ctrl_readdata <= beat_cnt;
                4'd7:    avs_ctrl_readdata <= byte_cnt;
                4'd8:    avs_ctrl_readdata <= {30'd0, done, busy};
`ifdef AVALON_ST_GENERATOR_THROTTLE_EN
                4'd9:    avs_ctrl_readdata <= {24'd0, throttle};
`endif
                default: avs_ctrl_readdata <= BAD_ADDR;
            endcase
        end
    end

    assign aso_data_data  = out_dat;
    assign aso_data_valid = out_vld;

endmodule

// File: tb/tb_avalon_st_generator.sv
module tb_avalon_st_generator;

    localparam int DATA_W = 256;
    localparam int N      = DATA_W / 16;

    logic              clk;
    logic              rst_n;
    logic [3:0]        address;
    logic              read;
    logic              write;
    logic [31:0]       readdata;
    logic [31:0]       writedata;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    int n_err = 0;
    int n_chk = 0;

    avalon_st_generator #(.DATA_W(DATA_W)) dut (
        .csi_clk_clk        (clk),
        .rsi_reset_reset_n  (rst_n),
        .avs_ctrl_address   (address),
        .avs_ctrl_read      (read),
        .avs_ctrl_write     (write),
        .avs_ctrl_readdata  (readdata),
        .avs_ctrl_writedata (writedata),
        .aso_data_data      (data),
        .aso_data_valid     (valid),
        .aso_data_ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        tick();
        d       = readdata;
        read    = 1'b0;
    endtask

    function automatic logic [15:0] sample(input int k);
        return data[k*16 +: 16];
    endfunction

    logic [DATA_W-1:0] init_pat;
    logic [31:0]       r;
    logic [15:0]       exp_s0;
    int                got;
    logic [7:0]        thr_seq;

    initial begin
        for (int i = 0; i < N; i++) init_pat[i*16 +: 16] = 16'(i);

        rst_n = 1'b0; address = 4'd0; read = 1'b0; write = 1'b0;
        writedata = 32'd0; ready = 1'b0;
        tick(); tick(); tick();

        // Reset state
        check("rst_readdata", readdata, 32'd0);
        check("rst_valid", valid, 1'b0);
        check("rst_data", data, init_pat);
        rst_n = 1'b1;

        rd(4'd0, r); check("reg_id", r, 32'ha5157e9e);
        rd(4'd1, r); check("reg_ver", r, 32'h00000100);
        rd(4'd2, r); check("reg_zero", r, 32'd0);
        rd(4'd3, r); check("reg_scratch_rst", r, 32'd0);
        rd(4'd5, r); check("reg_target_rst", r, 32'd0);
        rd(4'd6, r); check("reg_beats_rst", r, 32'd0);
        rd(4'd7, r); check("reg_bytes_rst", r, 32'd0);
        rd(4'd8, r); check("reg_status_rst", r, 32'd0);
        rd(4'd15, r); check("reg_unmapped", r, 32'hdeadbeef);
`ifdef AVALON_ST_GENERATOR_THROTTLE_EN
        rd(4'd9, r); check("reg_throttle_rst", r, 32'd0);
`else
        rd(4'd9, r); check("reg9_absent", r, 32'hdeadbeef);
`endif
        check("idle_valid", valid, 1'b0);

        wr(4'd3, 32'h12345678);
        rd(4'd3, r); check("scratch_rw", r, 32'h12345678);
        wr(4'd4, 32'h0000_0007 & 32'h2); // STOP while IDLE: no effect
        rd(4'd8, r); check("stop_in_idle", r, 32'd0);
        rd(4'd4, r); check("ctrl_reads_zero", r, 32'd0);

        // Fixed run of 4 beats at full rate
        wr(4'd5, 32'd4);
        ready = 1'b1;
        wr(4'd4, 32'h1);
        for (int k = 0; k < 4; k++) begin
            check("t4_valid", valid, 1'b1);
            check("t4_s0", sample(0), 16'(16 * k));
            if (k == 3) check("t4_s15", sample(15), 16'd63);
            tick();
        end
        check("t4_done_valid", valid, 1'b0);
        ready = 1'b0;
        rd(4'd8, r); check("t4_status", r, 32'd2);
        rd(4'd6, r); check("t4_beats", r, 32'd4);
        rd(4'd7, r); check("t4_bytes", r, 32'd128);

        // Toggling backpressure, restart from DONE
        wr(4'd5, 32'd3);
        wr(4'd4, 32'h1);
        rd(4'd8, r); check("t3_busy", r, 32'd1);
        exp_s0 = 16'd16 * 16'd0;
        // The read above spent one cycle with ready=0; pattern still at 0.
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            ready = (c % 2 == 0);
            check("t3_valid", valid, 1'b1);
            check("t3_s0", sample(0), exp_s0);
            tick();
            if (ready) begin
                exp_s0 = exp_s0 + 16'd16;
                got++;
            end
        end
        ready = 1'b0;
        check("t3_done_valid", valid, 1'b0);
        rd(4'd6, r); check("t3_beats", r, 32'd3);

        // Continuous run, STOP while a beat waits
        wr(4'd5, 32'd0);
        ready = 1'b1;
        wr(4'd4, 32'h1);
        for (int k = 0; k < 100; k++) tick();
        ready = 1'b0;
        wr(4'd4, 32'h2);
        check("stop_hold_valid", valid, 1'b1);
        check("stop_hold_s0", sample(0), 16'd1600);
        rd(4'd6, r); check("stop_beats_pending", r, 32'd100);
        check("stop_hold_s0_late", sample(0), 16'd1600);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("stop_after_valid", valid, 1'b0);
        rd(4'd6, r); check("stop_beats", r, 32'd101);
        rd(4'd7, r); check("stop_bytes", r, 32'd3232);
        rd(4'd8, r); check("stop_status", r, 32'd0);

        // CLEAR while a beat is presented and not accepted
        ready = 1'b1;
        wr(4'd4, 32'h1);
        for (int k = 0; k < 5; k++) tick();
        ready = 1'b0;
        check("clr_pre_valid", valid, 1'b1);
        check("clr_pre_s0", sample(0), 16'd80);
        wr(4'd4, 32'h4);
        check("clr_valid", valid, 1'b0);
        check("clr_data", data, init_pat);
        rd(4'd6, r); check("clr_beats", r, 32'd0);
        rd(4'd7, r); check("clr_bytes", r, 32'd0);
        rd(4'd8, r); check("clr_status", r, 32'd0);
        wr(4'd4, 32'h1);
        check("restart_valid", valid, 1'b1);
        check("restart_s0", sample(0), 16'd0);
        wr(4'd4, 32'h3); // STOP beats START: START ignored in RUN anyway, goes STOPPING
        check("stop_start_s0", sample(0), 16'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("stop_start_idle", valid, 1'b0);
        rd(4'd6, r); check("stop_start_beats", r, 32'd1);

`ifdef AVALON_ST_GENERATOR_THROTTLE_EN
        wr(4'd9, 32'd2);
        rd(4'd9, r); check("thr_rw", r, 32'd2);
        wr(4'd5, 32'd3);
        ready = 1'b1;
        wr(4'd4, 32'h1);
        thr_seq = 8'b0100_1001; // bit k = expected valid k cycles after START
        for (int k = 0; k < 8; k++) begin
            check("thr_valid", valid, thr_seq[k]);
            tick();
        end
        ready = 1'b0;
        rd(4'd6, r); check("thr_beats", r, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
